alu_result_checker: RTL and testbench
=====================================

// Module: alu_result_checker
// PURPOSE
//  Self-checking response monitor at the far end of the 5-bit ALU datapath: consumes
//  {A,B,Cin,Op,R,C} vectors through a valid/ready handshake, recomputes the golden
//  result, and keeps pass/fail counts plus the first mismatch. Runs for one batch of
//  N vectors per start pulse; lets ALU regressions run on-chip or in the bench without VCD review.
// PARAMETERS
//  W        5   operand/result width (A, B, R)
//  CNT_W    8   width of vector count, pass/fail counters, failure index
// PORTS
//  clk            in   1      rising-edge clock
//  rst_n          in   1      asynchronous active-low reset
//  start          in   1      one-cycle pulse: begin batch (accepted in IDLE or DONE only)
//  num_vec        in   CNT_W  vectors in batch, sampled on accepted start
//  in_valid       in   1      vector tuple valid
//  in_ready       out  1      checker can accept a tuple
//  a, b           in   W      ALU operands
//  cin            in   1      ALU carry-in
//  op             in   2      ALU opcode
//  r              in   W      ALU result under test
//  c              in   1      ALU carry/borrow under test
//  busy           out  1      state is RUN or DRAIN
//  done           out  1      level: batch complete (state DONE)
//  pass_cnt       out  CNT_W  vectors matching golden
//  fail_cnt       out  CNT_W  vectors mismatching golden
//  first_fail_vld out  1      a mismatch has been captured this batch
//  first_fail_idx out  CNT_W  0-based index of first mismatching vector
//  first_exp_r    out  W      golden R of first mismatch
//  first_exp_c    out  1      golden C of first mismatch
// BEHAVIOUR
//  - Reset: state IDLE; in_ready, busy, done, first_fail_vld = 0; all counters,
//    first_fail_idx, first_exp_r, first_exp_c = 0. Reset mid-batch discards everything.
//  - Golden model ({C,R} is W+1 bits, modulo 2^(W+1)):
//    op0 ADD: {C,R} = A + B + Cin;  op1 SUB: {C,R} = A - B - Cin (C = borrow);
//    op2 AND: R = A & B, C = 0;     op3 OR:  R = A | B, C = 0.
//  - Match requires both R and C equal; any X-free mismatch counts as fail.
//  - FSM: IDLE -start-> RUN (num_vec != 0) or DONE (num_vec == 0, next cycle).
//    RUN: in_ready = 1; transfer when in_valid & in_ready; after the num_vec-th
//    transfer -> DRAIN (in_ready = 0 from next cycle). DRAIN -> DONE once pipeline empty.
//    DONE -start-> as IDLE. start in RUN/DRAIN is ignored.
//  - Accepted start clears pass_cnt, fail_cnt, first_fail_* and the vector index.
//  - Pipeline: stage 1 registers tuple + index and computes golden; stage 2 compares
//    and updates counters. Counters reflect a vector exactly 2 cycles after its transfer.
//    Back-to-back transfers every cycle, no bubbles; in_ready never depends on in_valid.
//  - DONE entered the cycle after the last vector's counter update; pass_cnt +
//    fail_cnt == num_vec there. done stays high until next accepted start or reset.
//  - first_fail_* written only on first mismatch of batch; later mismatches don't overwrite.
//  - Counters cannot exceed num_vec, so no wrap handling; index wraps never occur.
//  - in_valid outside RUN is ignored (no transfer, no counter change).
// STRUCTURE
//  - Shared package alu_pkg: ALU_W = 5, opcode localparams OP_ADD=0, OP_SUB=1,
//    OP_AND=2, OP_OR=3, checker state encoding (IDLE, RUN, DRAIN, DONE).
//  - One sub-module: alu_golden (combinational golden model, same ports as the ALU:
//    a, b, cin, op -> r, c), reusable by other benches. FSM, pipeline, counters top-level.
// TESTING
//  1 num_vec=4, A=10000 B=01100 Cin=0 ops 0..3 with R/C = 11100/0, 00100/0,
//    00000/0, 11100/0 -> pass_cnt=4, fail_cnt=0, done, first_fail_vld=0.
//  2 A=11101 B=01100 Cin=0 op0 R=01001 C=1; A=00110 B=00111 Cin=1 op1 R=11110 C=1
//    -> both pass (carry out and borrow paths).
//  3 num_vec=3, vector 1 with corrupted R (A=00110 B=00111 Cin=1 op0, R=01101 vs golden
//    01110), vector 2 wrong C -> fail_cnt=2, first_fail_idx=1, first_exp_r=01110, first_exp_c=0.
//  4 in_valid toggled randomly, num_vec=8 -> no lost/duplicated vectors, counts sum to 8;
//    counter update observed exactly 2 cycles after each transfer.
//  5 num_vec=0 -> done one cycle after start, counters 0; start during RUN -> ignored.
//  6 rst_n low mid-RUN after 2 vectors -> all outputs to reset values; new start after
//    release runs a clean batch.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the 5-bit ALU datapath: widths, opcodes, and
// result-checker state encoding.
package alu_pkg;

  localparam int unsigned ALU_W = 5;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_OR  = 2'd3;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } chk_state_e;

endpackage

// File: rtl/alu_golden.sv
// Combinational reference model of the ALU; same ports as the ALU itself so
// other benches can reuse it.
module alu_golden
  import alu_pkg::*;
#(
  parameter int unsigned W = ALU_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic [1:0]   op,
  output logic [W-1:0] r,
  output logic         c
);

  logic [W:0] sum;
  logic [W:0] diff;

  // {c,r} is W+1 bits wide; for SUB the top bit is the borrow.
  assign sum  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign diff = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};

  always_comb begin
    r = '0;
    c = 1'b0;
    unique case (op)
      OP_ADD:  {c, r} = sum;
      OP_SUB:  {c, r} = diff;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_result_checker.sv
// Batch response monitor for the ALU: accepts result tuples, recomputes the
// golden answer and keeps pass/fail counts plus the first mismatch.
module alu_result_checker
  import alu_pkg::*;
#(
  parameter int unsigned W     = ALU_W,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             cin,
  input  logic [1:0]       op,
  input  logic [W-1:0]     r,
  input  logic             c,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             first_fail_vld,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [W-1:0]     first_exp_r,
  output logic             first_exp_c
);

  chk_state_e state_q, state_d;

  logic [CNT_W-1:0] num_q, idx_q;
  logic             s1_vld_q;
  logic [CNT_W-1:0] s1_idx_q;
  logic [W-1:0]     s1_r_q, s1_exp_r_q;
  logic             s1_c_q, s1_exp_c_q;

  logic [W-1:0] gold_r;
  logic         gold_c;
  logic         start_acc, xfer, last, match;

  alu_golden #(.W(W)) u_golden (
    .a   (a),
    .b   (b),
    .cin (cin),
    .op  (op),
    .r   (gold_r),
    .c   (gold_c)
  );

  assign in_ready  = (state_q == StRun);
  assign busy      = (state_q == StRun) || (state_q == StDrain);
  assign done      = (state_q == StDone);
  assign start_acc = start && ((state_q == StIdle) || (state_q == StDone));
  assign xfer      = in_valid && in_ready;
  assign last      = (idx_q == num_q - CNT_W'(1));
  assign match     = (s1_r_q == s1_exp_r_q) && (s1_c_q == s1_exp_c_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start) state_d = (num_vec == '0) ? StDone : StRun;
      StRun:          if (xfer && last) state_d = StDrain;
      // Stage 2 retires the final vector the cycle s1 goes empty.
      StDrain:        if (!s1_vld_q) state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  // Stage 1: register the tuple, its index and the golden answer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_q      <= '0;
      idx_q      <= '0;
      s1_vld_q   <= 1'b0;
      s1_idx_q   <= '0;
      s1_r_q     <= '0;
      s1_c_q     <= 1'b0;
      s1_exp_r_q <= '0;
      s1_exp_c_q <= 1'b0;
    end else begin
      s1_vld_q <= xfer;
      if (start_acc) begin
        num_q <= num_vec;
        idx_q <= '0;
      end else if (xfer) begin
        idx_q <= idx_q + CNT_W'(1);
      end
      if (xfer) begin
        s1_idx_q   <= idx_q;
        s1_r_q     <= r;
        s1_c_q     <= c;
        s1_exp_r_q <= gold_r;
        s1_exp_c_q <= gold_c;
      end
    end
  end

  // Stage 2: compare and update the batch statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_vld <= 1'b0;
      first_fail_idx <= '0;
      first_exp_r    <= '0;
      first_exp_c    <= 1'b0;
    end else if (start_acc) begin
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_vld <= 1'b0;
      first_fail_idx <= '0;
      first_exp_r    <= '0;
      first_exp_c    <= 1'b0;
    end else if (s1_vld_q) begin
      if (match) begin
        pass_cnt <= pass_cnt + CNT_W'(1);
      end else begin
        fail_cnt <= fail_cnt + CNT_W'(1);
        if (!first_fail_vld) begin
          first_fail_vld <= 1'b1;
          first_fail_idx <= s1_idx_q;
          first_exp_r    <= s1_exp_r_q;
          first_exp_c    <= s1_exp_c_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed, table-driven bench for alu_result_checker: batches of hand-computed
// vectors plus multi-cycle sequences for latency, start handling and reset.
module tb_alu_result_checker;

  localparam int unsigned W     = 5;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_vec = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     a = '0, b = '0, r = '0;
  logic             cin = 1'b0, c = 1'b0;
  logic [1:0]       op = '0;
  logic             busy, done;
  logic [CNT_W-1:0] pass_cnt, fail_cnt, first_fail_idx;
  logic             first_fail_vld, first_exp_c;
  logic [W-1:0]     first_exp_r;

  always #5 clk = ~clk;

  alu_result_checker #(.W(W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .num_vec        (num_vec),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .a              (a),
    .b              (b),
    .cin            (cin),
    .op             (op),
    .r              (r),
    .c              (c),
    .busy           (busy),
    .done           (done),
    .pass_cnt       (pass_cnt),
    .fail_cnt       (fail_cnt),
    .first_fail_vld (first_fail_vld),
    .first_fail_idx (first_fail_idx),
    .first_exp_r    (first_exp_r),
    .first_exp_c    (first_exp_c)
  );

  typedef struct {
    logic [4:0] a, b;
    logic       cin;
    logic [1:0] op;
    logic [4:0] r;
    logic       c;
  } vec_t;

  typedef struct {
    int         first, n, exp_pass, exp_fail;
    logic       exp_ffv;
    int         exp_idx;
    logic [4:0] exp_r;
    logic       exp_c;
  } batch_t;

  vec_t   vecs[9];
  batch_t batches[3];
  int     checks = 0;
  int     errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_vec(input int i);
    a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin;
    op = vecs[i].op; r = vecs[i].r; c = vecs[i].c;
  endtask

  task automatic do_start(input int n);
    start = 1'b1;
    num_vec = n[CNT_W-1:0];
    @(negedge clk);
    start = 1'b0;
  endtask

  // Back-to-back transfers, bounded wait on in_ready for each.
  task automatic send_batch(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      int guard = 0;
      drive_vec(first + i);
      in_valid = 1'b1;
      while (!in_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 50) check("send_ready_timeout", 32'd0, 32'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    check(name, done, 1);
  endtask

  task automatic check_results(input string tag, input int p, input int f, input logic ffv,
                               input int idx, input logic [4:0] er, input logic ec);
    check({tag, "_pass"}, pass_cnt, p);
    check({tag, "_fail"}, fail_cnt, f);
    check({tag, "_ffv"}, first_fail_vld, ffv);
    check({tag, "_fidx"}, first_fail_idx, idx);
    check({tag, "_fexpr"}, first_exp_r, er);
    check({tag, "_fexpc"}, first_exp_c, ec);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, in_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check_results(tag, 0, 0, 1'b0, 0, 5'b0, 1'b0);
  endtask

  initial begin
    vecs[0] = '{5'b10000, 5'b01100, 1'b0, 2'd0, 5'b11100, 1'b0};
    vecs[1] = '{5'b10000, 5'b01100, 1'b0, 2'd1, 5'b00100, 1'b0};
    vecs[2] = '{5'b10000, 5'b01100, 1'b0, 2'd2, 5'b00000, 1'b0};
    vecs[3] = '{5'b10000, 5'b01100, 1'b0, 2'd3, 5'b11100, 1'b0};
    vecs[4] = '{5'b11101, 5'b01100, 1'b0, 2'd0, 5'b01001, 1'b1};
    vecs[5] = '{5'b00110, 5'b00111, 1'b1, 2'd1, 5'b11110, 1'b1};
    vecs[6] = '{5'b00011, 5'b00101, 1'b0, 2'd2, 5'b00001, 1'b0};
    vecs[7] = '{5'b00110, 5'b00111, 1'b1, 2'd0, 5'b01101, 1'b0}; // golden 01110/0
    vecs[8] = '{5'b00001, 5'b00001, 1'b0, 2'd3, 5'b00001, 1'b1}; // golden 00001/0

    batches[0] = '{0, 4, 4, 0, 1'b0, 0, 5'b00000, 1'b0};
    batches[1] = '{4, 2, 2, 0, 1'b0, 0, 5'b00000, 1'b0};
    batches[2] = '{6, 3, 1, 2, 1'b1, 1, 5'b01110, 1'b0};

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      do_start(batches[i].n);
      check($sformatf("b%0d_busy", i), busy, 1);
      send_batch(batches[i].first, batches[i].n);
      wait_done($sformatf("b%0d_done", i));
      check($sformatf("b%0d_busy_end", i), busy, 0);
      check_results($sformatf("b%0d", i), batches[i].exp_pass, batches[i].exp_fail,
                    batches[i].exp_ffv, batches[i].exp_idx, batches[i].exp_r,
                    batches[i].exp_c);
    end

    // Random in_valid, 8 vectors; totals must trail transfers by exactly 2 cycles.
    begin
      int   sent = 0;
      int   cyc = 0;
      logic v, last_x;
      last_x = 1'b0;
      do_start(8);
      while (!done && cyc < 300) begin
        check("t4_latency", 32'(pass_cnt) + 32'(fail_cnt), sent - int'(last_x));
        v = (sent < 8) && ($urandom_range(0, 1) == 1);
        if (v) drive_vec(sent);
        in_valid = v;
        last_x = v && in_ready;
        if (last_x) sent++;
        @(negedge clk);
        cyc++;
      end
      in_valid = 1'b0;
      check("t4_done", done, 1);
      check("t4_sum", 32'(pass_cnt) + 32'(fail_cnt), 8);
      check_results("t4", 7, 1, 1'b1, 7, 5'b01110, 1'b0);
    end

    // Empty batch completes one cycle after start.
    do_start(0);
    check("t5_empty_done", done, 1);
    check_results("t5_empty", 0, 0, 1'b0, 0, 5'b0, 1'b0);

    // Start while running must not restart the batch.
    do_start(2);
    drive_vec(0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    do_start(5);
    check("t5_run_busy", busy, 1);
    send_batch(1, 1);
    wait_done("t5_ignore_done");
    check_results("t5_ignore", 2, 0, 1'b0, 0, 5'b0, 1'b0);

    // in_valid while DONE does nothing.
    drive_vec(8);
    in_valid = 1'b1;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    check("t5_idle_valid_done", done, 1);
    check_results("t5_idle_valid", 2, 0, 1'b0, 0, 5'b0, 1'b0);

    // Reset in the middle of a batch, then a clean batch.
    do_start(4);
    send_batch(7, 2);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("t6_after");
    do_start(1);
    send_batch(0, 1);
    wait_done("t6_done");
    check_results("t6", 1, 0, 1'b0, 0, 5'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
